// File: rtl/hnm_pp.sv
// hnm_pp - Hit-Nonzero Map, first stage of the HNM -> HCM -> HIM hit store.
// One flag bit per SSID, organised as NROWS_HNM rows of NCOLS_HNM bits.
// An SSID write sets the bit and reports whether it was already set, which
// tells the downstream stage whether this SSID is new. Also supports
// single-SSID reads, whole-row reads/writes and a sequential row-fill sweep.
// Optional build macro HNMPP_READ_CLEAR_EN: SSID reads clear the bit they
// report (read-and-clear drain). Without it, reads are non-destructive.
module hnm_pp #(
  parameter int ROWINDEXBITS_HNM = 4,
  parameter int COLINDEXBITS_HNM = 4,
  parameter int NROWS_HNM        = 2 ** ROWINDEXBITS_HNM,
  parameter int NCOLS_HNM        = 2 ** COLINDEXBITS_HNM,
  parameter int SSIDBITS         = ROWINDEXBITS_HNM + COLINDEXBITS_HNM
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        write,
  input  logic [SSIDBITS-1:0]         SSID_write,
  input  logic                        read,
  input  logic [SSIDBITS-1:0]         SSID_read,
  input  logic                        writeRow,
  input  logic [ROWINDEXBITS_HNM-1:0] rowWrite,
  input  logic [NCOLS_HNM-1:0]        dataWrite,
  input  logic                        readRow,
  input  logic [ROWINDEXBITS_HNM-1:0] rowRead,
  input  logic                        fillSequentialRows,
  output logic [SSIDBITS-1:0]         SSID_passed,
  output logic                        HNM_readOutput,
  output logic                        newOutput,
  output logic [ROWINDEXBITS_HNM-1:0] rowPassed,
  output logic [NCOLS_HNM-1:0]        rowReadOutput,
  output logic                        writeReady,
  output logic                        readReady,
  output logic                        busy
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_FILL = 1'b1;

  // SSID = {row, col}, row in the MSBs
  logic [ROWINDEXBITS_HNM-1:0] wr_row_s;
  logic [COLINDEXBITS_HNM-1:0] wr_col_s;
  logic [ROWINDEXBITS_HNM-1:0] rd_row_s;
  logic [COLINDEXBITS_HNM-1:0] rd_col_s;

  assign wr_row_s = SSID_write[SSIDBITS-1:COLINDEXBITS_HNM];
  assign wr_col_s = SSID_write[COLINDEXBITS_HNM-1:0];
  assign rd_row_s = SSID_read[SSIDBITS-1:COLINDEXBITS_HNM];
  assign rd_col_s = SSID_read[COLINDEXBITS_HNM-1:0];

  logic [NCOLS_HNM-1:0]        mem_q [NROWS_HNM];
  logic [NCOLS_HNM-1:0]        mem_d [NROWS_HNM];
  logic [0:0]                  state_q, state_d;
  logic [ROWINDEXBITS_HNM-1:0] fill_row_q, fill_row_d;
  logic [ROWINDEXBITS_HNM-1:0] fill_end_q, fill_end_d;
  logic [SSIDBITS-1:0]         ssid_passed_q, ssid_passed_d;
  logic                        hnm_read_q, hnm_read_d;
  logic                        new_q, new_d;
  logic [ROWINDEXBITS_HNM-1:0] row_passed_q, row_passed_d;
  logic [NCOLS_HNM-1:0]        row_read_q, row_read_d;
  logic                        busy_q, busy_d;

  // Next-state: IDLE serves strobes (fill pulse first), FILL sweeps rows.
  always_comb begin
    state_d       = state_q;
    fill_row_d    = fill_row_q;
    fill_end_d    = fill_end_q;
    mem_d         = mem_q;
    ssid_passed_d = ssid_passed_q;
    hnm_read_d    = hnm_read_q;
    new_d         = 1'b0;
    row_passed_d  = row_passed_q;
    row_read_d    = row_read_q;

    case (state_q)
      ST_IDLE: begin
        if (fillSequentialRows) begin
          // Fill pulse outranks every other strobe in this cycle.
          state_d    = ST_FILL;
          fill_row_d = {ROWINDEXBITS_HNM{1'b0}};
          fill_end_d = rowWrite;
        end else begin
          // Row write lands first so a same-row SSID set is ORed on top.
          mem_d[rowWrite] = writeRow ? dataWrite : mem_q[rowWrite];

          // Row read sees only the pre-edge contents.
          if (readRow) begin
            row_passed_d = rowRead;
            row_read_d   = mem_q[rowRead];
          end else begin
            row_passed_d = row_passed_q;
            row_read_d   = row_read_q;
          end

          if (write) begin
            ssid_passed_d              = SSID_write;
            hnm_read_d                 = mem_q[wr_row_s][wr_col_s];
            mem_d[wr_row_s][wr_col_s]  = 1'b1;
            new_d                      = 1'b1;
          end else if (read) begin
            ssid_passed_d = SSID_read;
            hnm_read_d    = mem_q[rd_row_s][rd_col_s];
`ifdef HNMPP_READ_CLEAR_EN
            mem_d[rd_row_s][rd_col_s] = 1'b0;
`endif
            new_d         = 1'b1;
          end else begin
            new_d = 1'b0;
          end
        end
      end

      ST_FILL: begin
        mem_d[fill_row_q] = dataWrite;
        if (fill_row_q == fill_end_q) begin
          state_d = ST_IDLE;
        end else begin
          fill_row_d = fill_row_q + ROWINDEXBITS_HNM'(1);
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d == ST_FILL);
  end

  // State, bit array and registered outputs; reset clears everything.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int r = 0; r < NROWS_HNM; r++) begin
        mem_q[r] <= {NCOLS_HNM{1'b0}};
      end
      state_q       <= ST_IDLE;
      fill_row_q    <= {ROWINDEXBITS_HNM{1'b0}};
      fill_end_q    <= {ROWINDEXBITS_HNM{1'b0}};
      ssid_passed_q <= {SSIDBITS{1'b0}};
      hnm_read_q    <= 1'b0;
      new_q         <= 1'b0;
      row_passed_q  <= {ROWINDEXBITS_HNM{1'b0}};
      row_read_q    <= {NCOLS_HNM{1'b0}};
      busy_q        <= 1'b0;
    end else begin
      mem_q         <= mem_d;
      state_q       <= state_d;
      fill_row_q    <= fill_row_d;
      fill_end_q    <= fill_end_d;
      ssid_passed_q <= ssid_passed_d;
      hnm_read_q    <= hnm_read_d;
      new_q         <= new_d;
      row_passed_q  <= row_passed_d;
      row_read_q    <= row_read_d;
      busy_q        <= busy_d;
    end
  end

  assign SSID_passed    = ssid_passed_q;
  assign HNM_readOutput = hnm_read_q;
  assign newOutput      = new_q;
  assign rowPassed      = row_passed_q;
  assign rowReadOutput  = row_read_q;
  assign busy           = busy_q;
  assign writeReady     = ~busy_q;
  assign readReady      = ~busy_q;

endmodule

// File: tb/tb_hnm_pp.sv
// Self-checking bench for hnm_pp: directed scenarios plus randomized traffic
// checked against a flat per-SSID bit model.
module tb_hnm_pp;

`ifdef HNMPP_READ_CLEAR_EN
  localparam bit READ_CLEARS = 1'b1;
`else
  localparam bit READ_CLEARS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        write;
  logic [7:0]  SSID_write;
  logic        read;
  logic [7:0]  SSID_read;
  logic        writeRow;
  logic [3:0]  rowWrite;
  logic [15:0] dataWrite;
  logic        readRow;
  logic [3:0]  rowRead;
  logic        fillSequentialRows;
  logic [7:0]  SSID_passed;
  logic        HNM_readOutput;
  logic        newOutput;
  logic [3:0]  rowPassed;
  logic [15:0] rowReadOutput;
  logic        writeReady;
  logic        readReady;
  logic        busy;

  hnm_pp dut (
    .clk(clk), .reset(reset),
    .write(write), .SSID_write(SSID_write),
    .read(read), .SSID_read(SSID_read),
    .writeRow(writeRow), .rowWrite(rowWrite), .dataWrite(dataWrite),
    .readRow(readRow), .rowRead(rowRead),
    .fillSequentialRows(fillSequentialRows),
    .SSID_passed(SSID_passed), .HNM_readOutput(HNM_readOutput),
    .newOutput(newOutput), .rowPassed(rowPassed),
    .rowReadOutput(rowReadOutput), .writeReady(writeReady),
    .readReady(readReady), .busy(busy)
  );

  always #5 clk = ~clk;

  // Reference: one flag per SSID value, plus the expected held outputs.
  logic        model [256];
  logic        exp_new;
  logic [7:0]  exp_ssid;
  logic        exp_hit;
  logic [3:0]  exp_row;
  logic [15:0] exp_rowdata;

  int n_cmp = 0;
  int n_mis = 0;

  localparam logic [7:0] LIST [23] = '{
    8'h88, 8'h33, 8'h35, 8'h88, 8'h44, 8'h12, 8'h88, 8'h33, 8'h44, 8'h35,
    8'h7F, 8'h00, 8'hFF, 8'h88, 8'h01, 8'h10, 8'h00, 8'hA5, 8'h5A, 8'hA5,
    8'hF0, 8'h0F, 8'hF0};

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    write = 1'b0; SSID_write = 8'h00; read = 1'b0; SSID_read = 8'h00;
    writeRow = 1'b0; rowWrite = 4'h0; dataWrite = 16'h0000;
    readRow = 1'b0; rowRead = 4'h0; fillSequentialRows = 1'b0;
  endtask

  task automatic clear_model();
    for (int i = 0; i < 256; i++) model[i] = 1'b0;
    exp_new = 1'b0; exp_ssid = 8'h00; exp_hit = 1'b0;
    exp_row = 4'h0; exp_rowdata = 16'h0000;
  endtask

  function automatic logic [15:0] model_row(input logic [3:0] r);
    logic [15:0] d;
    for (int c = 0; c < 16; c++) d[c] = model[r * 16 + c];
    return d;
  endfunction

  task automatic check_all(input string tag);
    check_eq({tag, ".new"},  32'(newOutput), 32'(exp_new));
    check_eq({tag, ".ssid"}, 32'(SSID_passed), 32'(exp_ssid));
    check_eq({tag, ".hit"},  32'(HNM_readOutput), 32'(exp_hit));
    check_eq({tag, ".row"},  32'(rowPassed), 32'(exp_row));
    check_eq({tag, ".rowd"}, 32'(rowReadOutput), 32'(exp_rowdata));
    check_eq({tag, ".busy"}, 32'(busy), 32'd0);
    check_eq({tag, ".wrdy"}, 32'(writeReady), 32'd1);
    check_eq({tag, ".rrdy"}, 32'(readReady), 32'd1);
  endtask

  // One IDLE cycle: drive strobes, predict from the model, clock, compare.
  task automatic step(input string tag,
                      input logic w, input logic [7:0] sw,
                      input logic r, input logic [7:0] sr,
                      input logic wr, input logic [3:0] rw, input logic [15:0] dw,
                      input logic rr, input logic [3:0] rrw);
    write = w; SSID_write = sw; read = r; SSID_read = sr;
    writeRow = wr; rowWrite = rw; dataWrite = dw;
    readRow = rr; rowRead = rrw; fillSequentialRows = 1'b0;

    exp_new = w | r;
    if (w) begin
      exp_ssid = sw; exp_hit = model[sw];
    end else if (r) begin
      exp_ssid = sr; exp_hit = model[sr];
    end
    if (rr) begin
      exp_row = rrw; exp_rowdata = model_row(rrw);
    end
    if (wr) for (int c = 0; c < 16; c++) model[rw * 16 + c] = dw[c];
    if (w) model[sw] = 1'b1;
    else if (r && READ_CLEARS) model[sr] = 1'b0;

    @(posedge clk); #1;
    idle_inputs();
    check_all(tag);
  endtask

  task automatic wr_ssid(input string tag, input logic [7:0] s);
    step(tag, 1'b1, s, 1'b0, 8'h00, 1'b0, 4'h0, 16'h0000, 1'b0, 4'h0);
  endtask

  task automatic rd_ssid(input string tag, input logic [7:0] s);
    step(tag, 1'b0, 8'h00, 1'b1, s, 1'b0, 4'h0, 16'h0000, 1'b0, 4'h0);
  endtask

  // Fill sweep of rows 0..endr while hammering every other strobe.
  task automatic do_fill(input string tag, input logic [3:0] endr, input logic [15:0] data);
    fillSequentialRows = 1'b1; rowWrite = endr; dataWrite = data;
    write = 1'b1; SSID_write = 8'($urandom);
    read = 1'b1; SSID_read = 8'($urandom);
    writeRow = 1'b1; readRow = 1'b1; rowRead = 4'($urandom);
    @(posedge clk); #1;
    check_eq({tag, ".start_busy"}, 32'(busy), 32'd1);
    check_eq({tag, ".start_wrdy"}, 32'(writeReady), 32'd0);
    check_eq({tag, ".start_rrdy"}, 32'(readReady), 32'd0);
    check_eq({tag, ".start_new"}, 32'(newOutput), 32'd0);
    fillSequentialRows = 1'b0;
    for (int k = 0; k <= int'(endr); k++) begin
      write = 1'b1; SSID_write = 8'($urandom);
      read = 1'b1; SSID_read = 8'($urandom);
      writeRow = 1'b1; rowWrite = 4'($urandom); dataWrite = data;
      readRow = 1'b1; rowRead = 4'($urandom);
      for (int c = 0; c < 16; c++) model[k * 16 + c] = data[c];
      @(posedge clk); #1;
      check_eq({tag, ".new"}, 32'(newOutput), 32'd0);
      check_eq({tag, ".busy"}, 32'(busy), 32'(k < int'(endr)));
      check_eq({tag, ".wrdy"}, 32'(writeReady), 32'(k >= int'(endr)));
      check_eq({tag, ".rowd"}, 32'(rowReadOutput), 32'(exp_rowdata));
    end
    idle_inputs();
    exp_new = 1'b0;
  endtask

  initial begin
    idle_inputs();
    clear_model();
    reset = 1'b0;
    #22;
    check_all("reset0");
    @(negedge clk) reset = 1'b1;

    // Some writes, then an asynchronous mid-stream reset.
    for (int i = 0; i < 6; i++) wr_ssid("pre", 8'($urandom));
    step("prerow", 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 4'h0, 16'h0000, 1'b1, 4'h2);
    #2 reset = 1'b0;
    #2;
    clear_model();
    check_all("midreset");
    @(negedge clk) reset = 1'b1;
    for (int i = 0; i < 8; i++) rd_ssid("postreset", 8'($urandom));

    // Back-to-back test-and-set.
    wr_ssid("b2b0", 8'h46);
    wr_ssid("b2b1", 8'h44);
    wr_ssid("b2b2", 8'h44);

    // Duplicate-laden list from a clean map.
    @(negedge clk) reset = 1'b0;
    #1;
    clear_model();
    @(negedge clk) reset = 1'b1;
    for (int i = 0; i < 23; i++) wr_ssid("list", LIST[i]);

    // Row write then row read, then single-bit reads.
    step("rowwr", 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 4'h3, 16'h00F0, 1'b0, 4'h0);
    step("rowrd", 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 4'h0, 16'h0000, 1'b1, 4'h3);
    check_eq("row3.idx", 32'(rowPassed), 32'h3);
    check_eq("row3.data", 32'(rowReadOutput), 32'h00F0);
    rd_ssid("rd34", 8'h34);
    rd_ssid("rd30", 8'h30);
    // Same-cycle row write and SSID write to that row: OR of both.
    step("rowor", 1'b1, 8'h51, 1'b1, 8'h22, 1'b1, 4'h5, 16'h8000, 1'b1, 4'h5);
    step("rowor_rd", 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 4'h0, 16'h0000, 1'b1, 4'h5);

    // Fill sweep rows 0..2, then inspect rows 0..3.
    do_fill("fill", 4'h2, 16'hFFFF);
    for (int r = 0; r < 4; r++)
      step("fillrd", 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 4'h0, 16'h0000, 1'b1, 4'(r));

    // Read-and-clear behaviour (both build variants predicted by the model).
    wr_ssid("rc_wr", 8'h12);
    rd_ssid("rc_rd1", 8'h12);
    check_eq("rc_first", 32'(HNM_readOutput), 32'd1);
    rd_ssid("rc_rd2", 8'h12);
    check_eq("rc_second", 32'(HNM_readOutput), READ_CLEARS ? 32'd0 : 32'd1);

    // Randomized mixed traffic with occasional fills.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 39) == 0) begin
        do_fill("rfill", 4'($urandom), 16'($urandom));
      end else begin
        step("rand",
             1'($urandom_range(0, 2) == 0), {4'($urandom_range(0, 3)), 4'($urandom)},
             1'($urandom_range(0, 1)),      {4'($urandom_range(0, 3)), 4'($urandom)},
             1'($urandom_range(0, 7) == 0), 4'($urandom_range(0, 3)), 16'($urandom),
             1'($urandom_range(0, 2) == 0), 4'($urandom_range(0, 3)));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
